tx_stream_sink: RTL
===================

Name: tx_stream_sink

Overview:
- Consumer end of the 32-bit stb/ack streams that the user design drives for transmitter frequency, AM level and control (output_tx_freq, output_tx_am, output_tx_ctl).
- Accepts words on each stream independently and holds each in a one-deep shadow register.
- Commits all pending shadows to the RF datapath registers together on an internal sample tick, so frequency and amplitude changes land on the same sample.
- Sits between user_design and the NCO/AM modulator.

Parameters:
- SAMPLE_DIV, 2000, clk cycles per sample tick (50 kHz at 100 MHz); legal range 2..65535.
- AM_BITS, 8, width of tx_am; taken from the low bits of the AM word.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_freq  in  32  frequency word
- in_freq_stb  in  1  frequency word valid
- in_freq_ack  out  1  frequency word accepted
- in_am  in  32  AM word; bits [AM_BITS-1:0] used
- in_am_stb  in  1  AM word valid
- in_am_ack  out  1  AM word accepted
- in_ctl  in  32  control word; bit0 = tx enable, other bits ignored
- in_ctl_stb  in  1  control word valid
- in_ctl_ack  out  1  control word accepted
- tx_freq  out  32  committed NCO frequency word
- tx_am  out  AM_BITS  committed amplitude
- tx_en  out  1  committed transmit enable
- sample_tick  out  1  one-cycle pulse when commits occur
- underrun_count  out  16  saturating underrun count (only with TX_UNDERRUN_CNT_EN; otherwise tied to 0)

Behaviour:
- Transfer rule: a transfer occurs at a rising edge where stb && ack are both high. ack is registered and high for exactly one cycle per transfer. The producer may hold stb continuously across several words.
- Per-channel FSM, identical for freq, am and ctl:
  - IDLE (ack=0): if stb && !pending, go to ACK with ack<=1.
  - ACK (ack=1): the transfer happens at this edge. shadow<=data, pending<=1, ack<=0, go to IDLE.
  - While pending=1, ack stays 0; this is back-pressure until the next tick.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - sample_tick is high on the cycle the counter equals SAMPLE_DIV-1.
  - First tick occurs SAMPLE_DIV cycles after rst is released.
- Commit on a tick cycle, per channel:
  - If pending, the active register takes the shadow value at that edge and pending clears.
  - Non-pending channels keep their previous value.
  - All channels update at the same edge; outputs are visible the cycle after sample_tick.
- Simultaneous transfer and tick on the same edge: the commit uses the pre-edge pending/shadow state. The newly captured word becomes pending and commits on the next tick. It is never lost or overwritten.
- Worst-case latency from transfer to output is SAMPLE_DIV+1 cycles. A channel accepts at most one word per tick period.
- Reset values: all acks 0, pending 0, shadows 0, tx_freq 0, tx_am 0, tx_en 0, sample_tick 0, tick counter 0, underrun_count 0.
- Reset mid-handshake: any word whose ack had not completed is discarded, and the producer must re-present it. Reset is required to force tx_en low within one cycle.

Optional Feature:
- Macro: TX_UNDERRUN_CNT_EN.
- With the macro: on each tick where tx_en (pre-edge) = 1 and AM pending = 0, underrun_count increments by 1, saturating at 16'hFFFF. It clears only on rst.
- Without the macro: no counter logic; underrun_count is constant 0.

Decomposition:
- Shared package tx_pkg:
  - CTL_TX_EN_BIT = 0
  - default SAMPLE_DIV
  - AM_BITS
  - underrun counter width 16
- One natural sub-module, stb_ack_shadow. It holds the per-channel FSM, shadow and pending, with a commit input and pending output. It is parameterised by width and instantiated three times.

Test Plan:
- Single freq word 32'h0123_4567 sent mid-period → ack pulses for 1 cycle; tx_freq = 32'h0123_4567 the cycle after the next sample_tick; tx_am and tx_en unchanged at 0.
- Freq 32'hAAAA_0000, am 32'h0000_00C8 and ctl 32'h1 sent in the same period → all three outputs change on the same edge (tx_am = 8'hC8, tx_en = 1).
- Two freq words back-to-back with stb held (SAMPLE_DIV=8):
  - First word: acked at once.
  - Second word: ack held low until the tick.
  - Outputs: word 1 appears after tick 1, word 2 after tick 2.
- Transfer edge coincides with sample_tick → that word is not committed on that tick; it appears after the following tick.
- With TX_UNDERRUN_CNT_EN, ctl=1 committed, then no AM words for 5 ticks → underrun_count = 5. A preload near saturation followed by further ticks stays at 16'hFFFF.
- rst asserted while in_am ack is high and tx_en=1 → next cycle all outputs 0 and ack 0; the re-presented word is accepted normally after release.

Source files
------------

// File: rtl/tx_stream_sink_pkg.sv
//------------------------------------------------------------------------------
// Module   : tx_pkg
// Brief    : Shared constants, channel state type and helpers for tx_stream_sink
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tx_pkg;

  localparam int CTL_TX_EN_BIT      = 0;
  localparam int SAMPLE_DIV_DEFAULT = 2000;
  localparam int AM_BITS_DEFAULT    = 8;
  localparam int UNDERRUN_W         = 16;
  localparam int TICK_CNT_W         = 16;

  typedef enum logic [0:0] {
    CH_IDLE = 1'b0,
    CH_ACK  = 1'b1
  } ch_state_t;

  function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_stream_sink_if.sv
//------------------------------------------------------------------------------
// Module   : tx_stream_sink_if
// Brief    : Freq / AM / control stb-ack streams from user design to the sink
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tx_stream_sink_if;

  logic [31:0] in_freq;
  logic        in_freq_stb;
  logic        in_freq_ack;
  logic [31:0] in_am;
  logic        in_am_stb;
  logic        in_am_ack;
  logic [31:0] in_ctl;
  logic        in_ctl_stb;
  logic        in_ctl_ack;

  modport master (
    output in_freq, in_freq_stb, in_am, in_am_stb, in_ctl, in_ctl_stb,
    input  in_freq_ack, in_am_ack, in_ctl_ack
  );

  modport slave (
    input  in_freq, in_freq_stb, in_am, in_am_stb, in_ctl, in_ctl_stb,
    output in_freq_ack, in_am_ack, in_ctl_ack
  );

endinterface

`default_nettype wire

// File: rtl/tx_stream_sink_stb_ack_shadow.sv
//------------------------------------------------------------------------------
// Module   : stb_ack_shadow
// Brief    : One stb/ack channel: accept one word into a shadow, hold it
//            pending (back-pressuring the producer) until a commit pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stb_ack_shadow
  import tx_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stb,
  output logic             ack,
  input  logic [WIDTH-1:0] data,
  input  logic             commit,
  output logic             pending,
  output logic [WIDTH-1:0] shadow
);

  ch_state_t r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CH_IDLE;
      ack     <= 1'b0;
      pending <= 1'b0;
      shadow  <= '0;
    end else begin
      if (commit) begin
        pending <= 1'b0;
      end
      // A capture only happens with pending already clear, so it never
      // collides with the commit clear above.
      case (r_state)
        CH_IDLE: begin
          if (stb && !pending) begin
            r_state <= CH_ACK;
            ack     <= 1'b1;
          end
        end
        CH_ACK: begin
          r_state <= CH_IDLE;
          ack     <= 1'b0;
          if (stb) begin
            shadow  <= data;
            pending <= 1'b1;
          end
        end
        default: begin
          r_state <= CH_IDLE;
          ack     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_stream_sink.sv
//------------------------------------------------------------------------------
// Module   : tx_stream_sink
// Brief    : Sink for freq/AM/ctl streams; shadows each word and commits all
//            pending shadows together on the sample tick.
//            Optional macro TX_UNDERRUN_CNT_EN adds a saturating underrun count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tx_stream_sink
  import tx_pkg::*;
#(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEFAULT,
  parameter int AM_BITS    = AM_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  tx_stream_sink_if.slave       strm,
  output logic [31:0]           tx_freq,
  output logic [AM_BITS-1:0]    tx_am,
  output logic                  tx_en,
  output logic                  sample_tick,
  output logic [UNDERRUN_W-1:0] underrun_count
);

  localparam logic [TICK_CNT_W-1:0] C_CNT_LAST = TICK_CNT_W'(SAMPLE_DIV - 1);
  localparam logic [TICK_CNT_W-1:0] C_CNT_PRE  = TICK_CNT_W'(SAMPLE_DIV - 2);

  logic [TICK_CNT_W-1:0] r_cnt;
  logic                  w_freq_pending;
  logic                  w_am_pending;
  logic                  w_ctl_pending;
  logic [31:0]           w_freq_shadow;
  logic [AM_BITS-1:0]    w_am_shadow;
  logic [0:0]            w_ctl_shadow;

  // Tick is registered one count early so it is high while r_cnt == SAMPLE_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      sample_tick <= 1'b0;
    end else begin
      r_cnt       <= (r_cnt == C_CNT_LAST) ? '0 : r_cnt + 1'b1;
      sample_tick <= (r_cnt == C_CNT_PRE);
    end
  end

  stb_ack_shadow #(.WIDTH(32)) u_freq (
    .clk     (clk),
    .rst     (rst),
    .stb     (strm.in_freq_stb),
    .ack     (strm.in_freq_ack),
    .data    (strm.in_freq),
    .commit  (sample_tick),
    .pending (w_freq_pending),
    .shadow  (w_freq_shadow)
  );

  stb_ack_shadow #(.WIDTH(AM_BITS)) u_am (
    .clk     (clk),
    .rst     (rst),
    .stb     (strm.in_am_stb),
    .ack     (strm.in_am_ack),
    .data    (strm.in_am[AM_BITS-1:0]),
    .commit  (sample_tick),
    .pending (w_am_pending),
    .shadow  (w_am_shadow)
  );

  stb_ack_shadow #(.WIDTH(1)) u_ctl (
    .clk     (clk),
    .rst     (rst),
    .stb     (strm.in_ctl_stb),
    .ack     (strm.in_ctl_ack),
    .data    (strm.in_ctl[CTL_TX_EN_BIT]),
    .commit  (sample_tick),
    .pending (w_ctl_pending),
    .shadow  (w_ctl_shadow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_freq <= '0;
      tx_am   <= '0;
      tx_en   <= 1'b0;
    end else if (sample_tick) begin
      if (w_freq_pending) tx_freq <= w_freq_shadow;
      if (w_am_pending)   tx_am   <= w_am_shadow;
      if (w_ctl_pending)  tx_en   <= w_ctl_shadow[0];
    end
  end

`ifdef TX_UNDERRUN_CNT_EN
  logic [UNDERRUN_W-1:0] r_underrun;

  // Transmitting through a tick with no fresh amplitude queued is an underrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrun <= '0;
    end else if (sample_tick && tx_en && !w_am_pending) begin
      r_underrun <= sat_inc(r_underrun);
    end
  end

  assign underrun_count = r_underrun;
`else
  assign underrun_count = '0;
`endif

  generate
    if (AM_BITS < 32) begin : g_am_unused
      wire w_unused_am = ^strm.in_am[31:AM_BITS];
    end
  endgenerate

  wire w_unused_ctl = ^strm.in_ctl[31:1];

endmodule

`default_nettype wire
